// File: rtl/dram_bank_pkg.sv
// dram_bank_pkg: shared constants and types for the DRAM bank storage model.
//   DEVICE_WIDTH / COLWIDTH / CHWIDTH : default data, column and row widths
//   NUM_ROWS                          : rows per bank at the default row width
//   access_e                          : meaning of the rd_o_wr strobe
package dram_bank_pkg;

  localparam int unsigned DEVICE_WIDTH = 4;
  localparam int unsigned COLWIDTH     = 10;
  localparam int unsigned CHWIDTH      = 5;
  localparam int unsigned NUM_ROWS     = 2**CHWIDTH;

  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } access_e;

endpackage

// File: rtl/dram_bank_if.sv
// dram_bank_if: per-cycle access bus of one DRAM bank.
//   rd_o_wr : 1 = write, 0 = read
//   dqin    : write data
//   dqout   : registered read data
//   row     : row address
//   column  : column address
// Modports: master (access generator), slave (bank).
interface dram_bank_if #(
  parameter int unsigned DEVICE_WIDTH = dram_bank_pkg::DEVICE_WIDTH,
  parameter int unsigned COLWIDTH     = dram_bank_pkg::COLWIDTH,
  parameter int unsigned CHWIDTH      = dram_bank_pkg::CHWIDTH
);
  import dram_bank_pkg::*;

  logic                    rd_o_wr;
  logic [DEVICE_WIDTH-1:0] dqin;
  logic [DEVICE_WIDTH-1:0] dqout;
  logic [CHWIDTH-1:0]      row;
  logic [COLWIDTH-1:0]     column;

  modport master (
    output rd_o_wr, dqin, row, column,
    input  dqout
  );

  modport slave (
    input  rd_o_wr, dqin, row, column,
    output dqout
  );

endinterface

// File: rtl/dram_bank_array.sv
// bank_array: single-port synchronous RAM holding the bank contents.
//   clk     : rising-edge clock
//   we      : write enable
//   re      : read enable; rd_data only updates on enabled reads
//   addr    : flattened {row,column} address
//   wr_data : write data
//   rd_data : registered read data
// Contents are never reset.
module bank_array
  import dram_bank_pkg::*;
#(
  parameter int unsigned DATA_W = dram_bank_pkg::DEVICE_WIDTH,
  parameter int unsigned ADDR_W = dram_bank_pkg::CHWIDTH + dram_bank_pkg::COLWIDTH,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
    if (re) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/dram_bank.sv
// dram_bank: behavioural storage model of one DRAM bank; one read or write
// per cycle to {row,column}, read data valid one cycle after the address edge.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (clears dqout, blocks writes,
//           keeps array contents)
//   bus   : dram_bank_if slave (rd_o_wr, dqin, dqout, row, column)
// Optional feature macro BANK_WR_FWD_EN: a write cycle also drives dqin onto
// dqout (write-through echo). Undefined: dqout holds during writes.
module dram_bank
  import dram_bank_pkg::*;
#(
  parameter int unsigned DEVICE_WIDTH = dram_bank_pkg::DEVICE_WIDTH,
  parameter int unsigned COLWIDTH     = dram_bank_pkg::COLWIDTH,
  parameter int unsigned CHWIDTH      = dram_bank_pkg::CHWIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  dram_bank_if.slave  bus
);

  localparam int unsigned NUM_COLS  = 2**COLWIDTH;
  localparam int unsigned BANK_ROWS = 2**CHWIDTH;
  localparam int unsigned ADDR_W    = CHWIDTH + COLWIDTH;

  access_e                 acc;
  logic                    we;
  logic                    re;
  logic [ADDR_W-1:0]       addr;
  logic [DEVICE_WIDTH-1:0] rd_data;
  logic [DEVICE_WIDTH-1:0] hold_q;
  logic                    rd_sel_q;

  always_comb begin
    acc  = access_e'(bus.rd_o_wr);
    we   = rst_n && (acc == ACC_WRITE);
    re   = rst_n && (acc == ACC_READ);
    addr = {bus.row, bus.column};
  end

  bank_array #(
    .DATA_W (DEVICE_WIDTH),
    .ADDR_W (ADDR_W),
    .DEPTH  (BANK_ROWS * NUM_COLS)
  ) u_array (
    .clk     (clk),
    .we      (we),
    .re      (re),
    .addr    (addr),
    .wr_data (bus.dqin),
    .rd_data (rd_data)
  );

  // The output register is split in two flops: the array's own read register
  // (loaded only on reads) and hold_q (reset / echoed data), with rd_sel_q
  // recording which one was loaded last. dqout is therefore a mux of
  // registers, keeping single-cycle read latency without a second stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q   <= '0;
      rd_sel_q <= 1'b0;
    end else if (acc == ACC_WRITE) begin
`ifdef BANK_WR_FWD_EN
      hold_q   <= bus.dqin;
      rd_sel_q <= 1'b0;
`else
      hold_q   <= hold_q;
      rd_sel_q <= rd_sel_q;
`endif
    end else begin
      rd_sel_q <= 1'b1;
    end
  end

  assign bus.dqout = rd_sel_q ? rd_data : hold_q;

endmodule

// File: tb/tb_dram_bank.sv
module tb_dram_bank;
  import dram_bank_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  // Reference model: sparse memory keyed by row*1024+col, expected dqout.
  logic [3:0] model [int];
  logic [3:0] exp_dq;
  bit         exp_known;
  int         written [$];

  dram_bank_if bus ();

  dram_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag);
    tests++;
    assert (bus.dqout === exp_dq) else begin
      fails++;
      $error("FAIL %s: dqout=%h expected=%h", tag, bus.dqout, exp_dq);
    end
  endtask

  // One access cycle: drive at negedge, apply model at posedge, check 1ns later.
  task automatic step(input bit rst, input bit wr, input int r, input int c,
                      input logic [3:0] d, input string tag);
    int a;
    @(negedge clk);
    rst_n       = ~rst;
    bus.rd_o_wr = wr;
    bus.row     = r[4:0];
    bus.column  = c[9:0];
    bus.dqin    = d;
    a = r * 1024 + c;
    @(posedge clk);
    if (rst) begin
      exp_dq    = 4'h0;
      exp_known = 1'b1;
    end else if (wr) begin
      model[a] = d;
      if (!(a inside {written})) written.push_back(a);
`ifdef BANK_WR_FWD_EN
      exp_dq    = d;
      exp_known = 1'b1;
`endif
    end else if (model.exists(a)) begin
      exp_dq    = model[a];
      exp_known = 1'b1;
    end else begin
      exp_known = 1'b0;
    end
    #1;
    if (exp_known) check(tag);
  endtask

  initial begin
    logic [3:0] burst [8];
    exp_dq    = 4'h0;
    exp_known = 1'b0;
    rst_n     = 1'b0;
    bus.rd_o_wr = 1'b0;
    bus.dqin  = '0;
    bus.row   = '0;
    bus.column = '0;

    // Reset for 2 cycles, with a write attempted during reset.
    step(1, 1, 0, 5, 4'h7, "rst_c0");
    step(1, 1, 0, 5, 4'h7, "rst_c1");
    step(0, 1, 0, 5, 4'h9, "post_rst_wr");
    step(1, 1, 0, 5, 4'h2, "rst_again");
    step(1, 0, 0, 5, 4'h0, "rst_again2");
    step(0, 0, 0, 5, 4'h0, "rst_kept_data");

    // Burst write row 1, cols 0..7, then read back.
    foreach (burst[i]) burst[i] = 4'($urandom_range(15, 0));
    for (int i = 0; i < 8; i++) step(0, 1, 1, i, burst[i], $sformatf("burst_wr%0d", i));
    for (int i = 0; i < 8; i++) step(0, 0, 1, i, 4'h0, $sformatf("burst_rd%0d", i));

    // Row isolation.
    step(0, 1, 1, 3, 4'hA, "iso_wr1");
    step(0, 1, 2, 3, 4'h5, "iso_wr2");
    step(0, 0, 1, 3, 4'h0, "iso_rd1");
    step(0, 0, 2, 3, 4'h0, "iso_rd2");

    // Address extremes.
    step(0, 1, 31, 1023, 4'hF, "ext_wr_hi");
    step(0, 1, 0, 0, 4'h1, "ext_wr_lo");
    step(0, 0, 31, 1023, 4'h0, "ext_rd_hi");
    step(0, 0, 0, 0, 4'h0, "ext_rd_lo");

    // Write then immediate read.
    step(0, 1, 5, 9, 4'h6, "wr_then_rd_w");
    step(0, 0, 5, 9, 4'h0, "wr_then_rd_r");

    // Reset mid-op drops the in-flight write.
    step(0, 1, 1, 0, 4'h3, "mid_wr");
    step(1, 1, 1, 0, 4'hC, "mid_rst");
    step(0, 0, 1, 0, 4'h0, "mid_rd");

    // Randomized mix of reads (of written locations), writes and resets.
    for (int n = 0; n < 300; n++) begin
      int unsigned kind = $urandom_range(99, 0);
      int a;
      if (kind < 5) begin
        step(1, $urandom_range(1, 0), $urandom_range(31, 0), $urandom_range(1023, 0),
             4'($urandom_range(15, 0)), $sformatf("rnd_rst%0d", n));
      end else if (kind < 50 || written.size() == 0) begin
        if ($urandom_range(1, 0) == 1 && written.size() != 0)
          a = written[$urandom_range(written.size() - 1, 0)];
        else
          a = int'($urandom_range(32767, 0));
        step(0, 1, a / 1024, a % 1024, 4'($urandom_range(15, 0)), $sformatf("rnd_wr%0d", n));
      end else begin
        a = written[$urandom_range(written.size() - 1, 0)];
        step(0, 0, a / 1024, a % 1024, 4'h0, $sformatf("rnd_rd%0d", n));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
